// File: rtl/uart_stream_tester.sv
// UART loopback/stream tester: RX words are transformed into a FIFO (or a
// pattern burst is generated) and drained through a handshaked TX FSM.
module uart_stream_tester #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned BURST_LEN    = 32,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  overflow,
    output logic                  burst_active
);

    localparam int unsigned CW     = ADDR_WIDTH + 1;
    localparam int unsigned TMO_W  = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [CW-1:0]         DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] DATA_ONE = DATA_WIDTH'(1);
    localparam logic [7:0]            BURST_C  = 8'(BURST_LEN);
    localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);
    localparam logic [TMO_W-1:0]      TMO_ONE  = TMO_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_HI,
        ST_WAIT_LO
    } tx_state_e;

    tx_state_e               state_q, state_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic                    tx_start_q, tx_start_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic                    burst_active_q, burst_active_d;
    logic [7:0]              remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0]   value_q, value_d;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];

    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    pop;
    logic                    full;
    logic                    empty;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // Write source: burst generator in mode 3, transformed RX words otherwise.
    always_comb begin
        wr_en          = 1'b0;
        wr_data        = rx_data;
        overflow_d     = overflow_q;
        burst_active_d = burst_active_q;
        remaining_d    = remaining_q;
        value_d        = value_q;
        if (mode == 2'd3) begin
            if (burst_active_q) begin
                if (!full) begin
                    wr_en       = 1'b1;
                    wr_data     = value_q;
                    value_d     = value_q + DATA_ONE;
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) begin
                        burst_active_d = 1'b0;
                    end
                end
            end else if (start) begin
                burst_active_d = 1'b1;
                remaining_d    = BURST_C;
                value_d        = seed;
            end
        end else begin
            burst_active_d = 1'b0;
            if (rx_valid) begin
                if (full) begin
                    overflow_d = 1'b1;
                end else begin
                    wr_en = 1'b1;
                    case (mode)
                        2'd1:    wr_data = rx_data + DATA_ONE;
                        2'd2:    wr_data = ~rx_data;
                        default: wr_data = rx_data;
                    endcase
                end
            end
        end
    end

    // TX handshake FSM; the pop happens in IDLE as the head is latched.
    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty && !tx_busy) begin
                    tx_data_d  = mem_q[rd_ptr_q];
                    pop        = 1'b1;
                    tx_start_d = 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                tmo_d   = '0;
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_LO;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d  = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!wr_en && pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            tmo_q          <= '0;
            tx_start_q     <= 1'b0;
            tx_data_q      <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            overflow_q     <= 1'b0;
            burst_active_q <= 1'b0;
            remaining_q    <= '0;
            value_q        <= '0;
        end else begin
            state_q        <= state_d;
            tmo_q          <= tmo_d;
            tx_start_q     <= tx_start_d;
            tx_data_q      <= tx_data_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            overflow_q     <= overflow_d;
            burst_active_q <= burst_active_d;
            remaining_q    <= remaining_d;
            value_q        <= value_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign tx_start     = tx_start_q;
    assign tx_data      = tx_data_q;
    assign fifo_count   = count_q;
    assign overflow     = overflow_q;
    assign burst_active = burst_active_q;

endmodule

// File: tb/tb_uart_stream_tester.sv
// Scoreboard bench for uart_stream_tester: expected TX words are queued at
// stimulus time and compared as the bench (acting as the UART) accepts them.
module tb_uart_stream_tester;

    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 4;
    localparam int unsigned BL  = 4;
    localparam int unsigned TMO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic          start;
    logic [DW-1:0] seed;
    logic          rx_valid;
    logic [DW-1:0] rx_data;
    logic          tx_busy;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic [AW:0]   fifo_count;
    logic          overflow;
    logic          burst_active;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    uart_stream_tester #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(16), .ADDR_WIDTH(AW),
        .BURST_LEN(BL), .BUSY_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .seed(seed),
        .rx_valid(rx_valid), .rx_data(rx_data), .tx_busy(tx_busy),
        .tx_start(tx_start), .tx_data(tx_data), .fifo_count(fifo_count),
        .overflow(overflow), .burst_active(burst_active)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] xform(input logic [1:0] m, input logic [DW-1:0] d);
        case (m)
            2'd1:    return d + 8'd1;
            2'd2:    return ~d;
            default: return d;
        endcase
    endfunction

    task automatic send_rx(input logic [DW-1:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Acts as the UART: wait for tx_start, capture tx_data, then hold busy.
    task automatic serve_word(input int busy_cycles, output logic [DW-1:0] d, output bit ok);
        ok = 1'b0;
        d  = '0;
        for (int i = 0; i < 200; i++) begin
            if (tx_start === 1'b1) begin
                ok = 1'b1;
                d  = tx_data;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            if (busy_cycles > 0) begin
                tx_busy = 1'b1;
                repeat (busy_cycles) @(negedge clk);
                tx_busy = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic count_starts(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (tx_start === 1'b1) n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; mode = 2'd0; start = 1'b0; seed = '0;
        rx_valid = 1'b0; rx_data = '0; tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %0b exp 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %0h exp 0", tx_data); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_fifo_count got %0d exp 0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
        checks++; if (burst_active !== 1'b0) begin errors++; $display("FAIL reset_burst_active got %0b exp 0", burst_active); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_echo();
        logic [DW-1:0] got, exp;
        bit ok;
        mode = 2'd0;
        exp_q.push_back(xform(2'd0, 8'h41));
        send_rx(8'h41);
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL echo_latency_early got %0b exp 0", tx_start); end
        @(negedge clk);
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL echo_latency got %0b exp 1", tx_start); end
        serve_word(10, got, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL echo_data got timeout exp tx_start"); end
        else begin exp = exp_q.pop_front(); if (got !== exp) begin errors++; $display("FAIL echo_data got %0h exp %0h", got, exp); end end
        repeat (3) @(negedge clk);
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL echo_fifo_count got %0d exp 0", fifo_count); end
    endtask

    task automatic test_transform();
        logic [DW-1:0] got, exp;
        bit ok;
        logic [1:0]    modes [2];
        logic [DW-1:0] words [2];
        modes[0] = 2'd1; words[0] = 8'hFF;
        modes[1] = 2'd2; words[1] = 8'h0F;
        for (int i = 0; i < 2; i++) begin
            mode = modes[i];
            exp_q.push_back(xform(modes[i], words[i]));
            send_rx(words[i]);
            serve_word(3, got, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL transform_%0d got timeout exp tx_start", i); end
            else begin exp = exp_q.pop_front(); if (got !== exp) begin errors++; $display("FAIL transform_%0d got %0h exp %0h", i, got, exp); end end
            repeat (4) @(negedge clk);
        end
        mode = 2'd0;
    endtask

    task automatic test_burst();
        logic [DW-1:0] got, exp;
        bit ok;
        int n;
        mode = 2'd3;
        seed = 8'hFE;
        for (int i = 0; i < int'(BL); i++) exp_q.push_back(8'(seed + 8'(i)));
        start = 1'b1;
        @(negedge clk);
        fork
            begin
                checks++; if (burst_active !== 1'b1) begin errors++; $display("FAIL burst_active_set got %0b exp 1", burst_active); end
                start    = 1'b1;
                rx_valid = 1'b1;
                rx_data  = 8'h77;
                @(negedge clk);
                start    = 1'b0;
                rx_valid = 1'b0;
                repeat (2) @(negedge clk);
                checks++; if (burst_active !== 1'b1) begin errors++; $display("FAIL burst_active_before_last got %0b exp 1", burst_active); end
                @(negedge clk);
                checks++; if (burst_active !== 1'b0) begin errors++; $display("FAIL burst_active_clear got %0b exp 0", burst_active); end
            end
            begin
                for (int i = 0; i < int'(BL); i++) begin
                    serve_word(5, got, ok);
                    checks++;
                    if (!ok) begin errors++; $display("FAIL burst_data_%0d got timeout exp tx_start", i); end
                    else begin exp = exp_q.pop_front(); if (got !== exp) begin errors++; $display("FAIL burst_data_%0d got %0h exp %0h", i, got, exp); end end
                end
            end
        join
        count_starts(20, n);
        checks++; if (n != 0) begin errors++; $display("FAIL burst_extra_words got %0d exp 0", n); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL burst_overflow got %0b exp 0", overflow); end
        mode = 2'd0;
    endtask

    task automatic test_timeout();
        logic [DW-1:0] got, exp;
        bit ok;
        int n;
        int gap;
        mode = 2'd0;
        tx_busy = 1'b0;
        exp_q.push_back(xform(2'd0, 8'h5A));
        send_rx(8'h5A);
        serve_word(0, got, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL timeout_data got timeout exp tx_start"); end
        else begin exp = exp_q.pop_front(); if (got !== exp) begin errors++; $display("FAIL timeout_data got %0h exp %0h", got, exp); end end
        count_starts(30, n);
        checks++; if (n != 0) begin errors++; $display("FAIL timeout_retransmit got %0d exp 0", n); end
        exp_q.push_back(xform(2'd0, 8'hA1));
        exp_q.push_back(xform(2'd0, 8'hA2));
        send_rx(8'hA1);
        send_rx(8'hA2);
        serve_word(0, got, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL timeout_first got timeout exp tx_start"); end
        else begin exp = exp_q.pop_front(); if (got !== exp) begin errors++; $display("FAIL timeout_first got %0h exp %0h", got, exp); end end
        for (gap = 1; gap < 50 && tx_start !== 1'b1; gap++) @(negedge clk);
        checks++; if (gap != int'(TMO) + 2) begin errors++; $display("FAIL timeout_spacing got %0d exp %0d", gap, TMO + 2); end
        got = tx_data;
        exp = exp_q.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL timeout_second got %0h exp %0h", got, exp); end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_overflow();
        logic [DW-1:0] got, exp;
        bit ok;
        int n;
        mode = 2'd0;
        tx_busy = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(i);
            if (i < 16) exp_q.push_back(8'(i));
            @(negedge clk);
        end
        rx_valid = 1'b0;
        @(negedge clk);
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL ovf_fifo_count got %0d exp 16", fifo_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", overflow); end
        tx_busy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            serve_word(2, got, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL ovf_data_%0d got timeout exp tx_start", i); end
            else begin exp = exp_q.pop_front(); if (got !== exp) begin errors++; $display("FAIL ovf_data_%0d got %0h exp %0h", i, got, exp); end end
        end
        count_starts(20, n);
        checks++; if (n != 0) begin errors++; $display("FAIL ovf_dropped_sent got %0d exp 0", n); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", overflow); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL ovf_drained got %0d exp 0", fifo_count); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] got, exp;
        bit ok;
        int n;
        mode = 2'd0;
        tx_busy = 1'b1;
        for (int i = 0; i < 6; i++) send_rx(8'(8'h60 + 8'(i)));
        @(negedge clk);
        tx_busy = 1'b0;
        for (int i = 0; i < 20 && tx_start !== 1'b1; i++) @(negedge clk);
        tx_busy = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (fifo_count !== 5'd5) begin errors++; $display("FAIL rstmid_queued got %0d exp 5", fifo_count); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({tx_start, tx_data, fifo_count, overflow, burst_active} !== '0) begin
            errors++;
            $display("FAIL rstmid_async got start=%0b data=%0h cnt=%0d ovf=%0b burst=%0b exp all 0",
                     tx_start, tx_data, fifo_count, overflow, burst_active);
        end
        @(negedge clk);
        rst = 1'b1;
        tx_busy = 1'b0;
        count_starts(30, n);
        checks++; if (n != 0) begin errors++; $display("FAIL rstmid_no_start got %0d exp 0", n); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL rstmid_fifo_count got %0d exp 0", fifo_count); end
        exp_q.push_back(xform(2'd0, 8'h3C));
        send_rx(8'h3C);
        serve_word(3, got, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rstmid_new_word got timeout exp tx_start"); end
        else begin exp = exp_q.pop_front(); if (got !== exp) begin errors++; $display("FAIL rstmid_new_word got %0h exp %0h", got, exp); end end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_echo();
        test_transform();
        test_burst();
        test_timeout();
        test_overflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_stream_tester.md
Name: uart_stream_tester

Overview:
Parametrised successor to the board-level UART loopback test. It sits between a UART core's RX/TX byte interfaces and the board controls. Received words pass through a selectable transform and a FIFO, then go back out through a TX handshake FSM. A pattern-burst mode generates a fixed-length test sequence on a button tick. Status outputs drive LEDs.

Parameters:
DATA_WIDTH, 8, width of rx_data/tx_data/seed.
FIFO_DEPTH, 16, FIFO entries; power of two, at least 2.
ADDR_WIDTH, 4, log2(FIFO_DEPTH).
BURST_LEN, 32, words emitted per burst; 1..255.
BUSY_TIMEOUT, 4, cycles to wait for tx_busy after tx_start; at least 1.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
mode  in  2  0 echo, 1 increment, 2 invert, 3 burst
start  in  1  one-cycle pulse (debounced button tick); starts a burst
seed  in  DATA_WIDTH  first burst word
rx_valid  in  1  one-cycle pulse; rx_data valid
rx_data  in  DATA_WIDTH  received word
tx_busy  in  1  UART transmitter busy
tx_start  out  1  one-cycle request to UART TX
tx_data  out  DATA_WIDTH  word to transmit; stable from tx_start until tx_busy falls
fifo_count  out  ADDR_WIDTH+1  current FIFO occupancy, 0..FIFO_DEPTH
overflow  out  1  sticky; set when any write is dropped
burst_active  out  1  high while burst words remain to be written

Behaviour:
- Reset (rst=0, asynchronous): tx_start=0, tx_data=0, fifo_count=0, overflow=0, burst_active=0.
- Reset also puts the FIFO pointers at 0, the TX FSM in IDLE and the burst counter at 0.
- Asserting reset mid-transfer drops tx_start immediately and discards FIFO contents.
- Transform, applied at write time; all arithmetic is modulo 2^DATA_WIDTH:
  - mode 0 (echo): write rx_data.
  - mode 1 (increment): write rx_data+1.
  - mode 2 (invert): write ~rx_data.
- Mode 3 (burst): rx_valid words are discarded silently. They are not counted as overflow.
- Burst start: start=1 in mode 3 with burst_active=0 loads remaining=BURST_LEN and value=seed, and sets burst_active the next cycle.
  - start while burst_active=1 is ignored.
  - start in modes 0-2 is ignored.
- Burst writes: each cycle with burst_active=1 and fifo_count<FIFO_DEPTH, write value, then value+=1 and remaining-=1.
  - burst_active clears in the cycle after the final write.
  - While the FIFO is full, the generator stalls. Stalling is not overflow.
- A mode change away from 3 while burst_active=1 aborts the burst in the next cycle; words already written stay in the FIFO.
- FIFO write rule (RX path): a write is accepted only if fifo_count<FIFO_DEPTH at the start of the cycle.
  - A write while full is dropped and sets overflow, even if a pop occurs in the same cycle.
- Simultaneous write and pop: the pointers both advance and fifo_count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Full is fifo_count==FIFO_DEPTH; empty is fifo_count==0.
- TX FSM states and transitions:
  - IDLE: if fifo_count>0 and tx_busy=0, latch head to tx_data, pop, go to START.
  - START: tx_start=1 for exactly this cycle; go to WAIT_HI.
  - WAIT_HI: tx_busy=1 goes to WAIT_LO. If BUSY_TIMEOUT cycles elapse without tx_busy, go to IDLE; the word is treated as sent.
  - WAIT_LO: tx_busy=0 goes to IDLE.
- Latency: an RX word written into an empty FIFO pops in the next cycle (IDLE sees it). tx_start rises 2 cycles after the rx_valid cycle.
- Minimum spacing between tx_start pulses is 3 cycles. tx_start never asserts while tx_busy=1 in IDLE.
- overflow clears only on reset.

Test Plan:
- Echo: mode=0, rx_data=0x41 pulse; tx_busy high 10 cycles after tx_start. Expect tx_start exactly 2 cycles after rx_valid, tx_data=0x41, fifo_count back to 0.
- Transform wrap: mode=1 with 0xFF, then mode=2 with 0x0F. Expect tx_data 0x00, then 0xF0.
- Overflow: mode=0, tx_busy held 1. Send 17 rx words 0x00..0x10. Expect fifo_count=16, overflow=1, and 0x10 dropped. Release tx_busy: output 0x00..0x0F in order.
- Burst: mode=3, seed=0xFE, BURST_LEN=4, start pulse, UART model busy 5 cycles per word. Expect tx_data sequence FE, FF, 00, 01; burst_active low after the 4th write; overflow=0. A second start mid-burst is ignored.
- Timeout: tx_busy tied 0, one word queued. Expect a single tx_start pulse, a return to IDLE after BUSY_TIMEOUT cycles, and no retransmit.
- Reset mid-transfer: assert rst=0 during WAIT_LO with 5 words queued. Expect all outputs 0 asynchronously; after release, no tx_start until a new rx_valid.
